midi_tx_arbiter: RTL and testbench
==================================

# midi_tx_arbiter

Shares one MIDI UART transmitter between up to NUM_REQ byte-stream requesters, for example a sequencer, a SysEx engine and a CPU mailbox. Every MIDI message goes out atomically, and grants rotate round-robin. The block runs in the MIDI system clock domain produced by the MIDI clock generator. It uses that generator's keep_alive pulse to inject Active Sensing (0xFE) when the line has been idle, and it aborts any grant whose owner stalls mid-message.

## Interface
Parameters:
- NUM_REQ, 4: number of requester ports, 2..8.
- STALL_MAX, 1024: number of consecutive cycles a granted requester may hold req_valid low mid-message before the grant is revoked. Range 1..65535.

Ports:
- midi_system_clock, in, 1: the single clock (250 kHz system tick).
- midi_rst_n, in, 1: asynchronous active-low reset.
- keep_alive, in, 1: single-cycle pulse, about 3.8 Hz, synchronous to midi_system_clock.
- req_valid, in, NUM_REQ: per-requester byte valid.
- req_data, in, 8*NUM_REQ: requester i drives bits [8i+7:8i].
- req_last, in, NUM_REQ: the current byte is the final byte of its message.
- req_ready, out, NUM_REQ: per-requester byte accepted.
- tx_valid, out, 1: byte offered to the UART.
- tx_data, out, 8: byte to the UART.
- tx_ready, in, 1: UART accepts the byte.
- grant, out, NUM_REQ: one-hot current owner; all zero when no requester owns the UART.
- busy, out, 1: the FSM is not in IDLE.
- stall_abort, out, 1: one-cycle pulse when a grant is revoked by a stall.

## Operation
- FSM states: IDLE, XFER, SENSE.
- IDLE:
  - If any req_valid is high, select the first requester in round-robin order starting at rr_ptr. Register its grant and go to XFER.
  - Otherwise, if sense_pending is set (only when MIDI_ACTIVE_SENSE_EN is defined), go to SENSE.
  - Requesters have priority over Active Sensing.
- XFER, with g the granted requester:
  - tx_valid = req_valid[g] and tx_data = req_data[g].
  - req_ready[g] = tx_ready. All other req_ready bits are 0.
  - A handshake is tx_valid & tx_ready.
  - On a handshake with req_last[g] high: go to IDLE and set rr_ptr = g+1 (mod NUM_REQ).
  - Stall counter: increments every cycle req_valid[g] is 0 and clears on every handshake. When it reaches STALL_MAX: pulse stall_abort, go to IDLE, and advance rr_ptr as above. No byte is sent in that cycle.
- SENSE:
  - tx_valid = 1 and tx_data = 0xFE. grant is 0.
  - On tx_ready: clear sense_pending and go to IDLE.
- Activity tracking:
  - The activity flag is set by any handshake, including the 0xFE byte itself.
  - On a keep_alive pulse: if activity is 0, set sense_pending; in all cases clear activity.
  - A handshake in the same cycle as keep_alive counts as activity, so sense_pending is not set.
- Requester protocol:
  - Once req_valid[g] rises, req_data and req_last are held until the byte is accepted.
  - The block never drops or reorders bytes of a granted requester.

## Timing
- Reset values:
  - Outputs: grant 0, tx_valid 0, tx_data 0x00, req_ready 0, busy 0, stall_abort 0.
  - Internal state: rr_ptr 0, activity 0, sense_pending 0, stall counter 0, state IDLE.
- Arbitration latency: req_valid high in IDLE at cycle n gives grant and busy at n+1. The first handshake is possible at n+1.
- Data path: XFER is combinational pass-through from req_* to tx_* and from tx_ready to req_ready. grant is registered.
- Message gap: there is at least one IDLE cycle between consecutive messages, and between a message and a 0xFE byte.
- Single-byte messages (req_last high on the first byte) complete in one XFER cycle if tx_ready is high.
- Stall counter: width is clog2(STALL_MAX+1) bits, and it saturates without wrapping. stall_abort is registered and aligned with the IDLE entry cycle.
- Asynchronous reset mid-message clears all state. Any partially sent message is abandoned, and the UART sees tx_valid drop immediately.

## Configuration
- MIDI_ACTIVE_SENSE_EN defined: the activity flag, sense_pending and the SENSE state are built, and 0xFE is injected as described in Operation.
- Not defined: keep_alive is ignored, the SENSE state is unreachable or removed, and tx_data only ever carries requester bytes.

## Test plan
- Single requester: req 0 sends 0x90, 0x3C, 0x64 with last on 0x64, tx_ready held high. Expect grant=0001 one cycle after req_valid, three consecutive tx bytes, then busy=0.
- Round-robin: reqs 1 and 3 both valid with 1-byte messages 0xF8/0xFA, rr_ptr=0. Expect order 1 then 3, then 1 again if it re-requests while 3 is still pending.
- Atomicity: req 2 mid-message while req 0 asserts valid. Expect no req 0 byte until after req 2's last byte plus one IDLE cycle.
- Stall: req 1 sends 0xB0 and then drops valid for STALL_MAX=16 cycles. Expect stall_abort pulse on cycle 16, grant cleared, and the next requester served.
- Active sensing (MIDI_ACTIVE_SENSE_EN): no traffic, keep_alive pulse. Expect one 0xFE byte. A second pulse with the 0xFE accepted in between produces no 0xFE. A pulse coincident with a handshake produces no 0xFE.
- Reset mid-transfer: assert midi_rst_n low during byte 2 of 3. Expect tx_valid, grant and req_ready at 0 immediately, and rr_ptr=0 after release.

Source files
------------

// File: rtl/midi_tx_arbiter.sv
// Round-robin arbiter sharing one MIDI UART transmitter between byte-stream requesters.
// Optional Active Sensing (0xFE) injection is built when MIDI_ACTIVE_SENSE_EN is defined.
module midi_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int STALL_MAX = 1024
) (
  input  logic                   midi_system_clock,
  input  logic                   midi_rst_n,
  input  logic                   keep_alive,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   stall_abort
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    SENSE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
  logic               abort_q, abort_d;

  logic [PW-1:0]      sel;
  logic               any_req;
  int                 idx;
  logic               found;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic [PW-1:0]      rr_next;
  logic [SW-1:0]      stall_inc;
  logic               hs;
  logic               sense_go;

  assign g_valid = req_valid[gidx_q];
  assign g_last  = req_last[gidx_q];
  assign g_data  = req_data[{gidx_q, 3'b000} +: 8];

  assign rr_next = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  assign stall_inc = (stall_cnt_q == SW'(STALL_MAX)) ?
                     stall_cnt_q : stall_cnt_q + 1'b1;

  assign any_req = |req_valid;

  // First valid requester scanning upward from rr_ptr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    unique case (state_q)
      XFER: begin
        tx_valid  = g_valid;
        tx_data   = g_data;
        req_ready = grant_q & {NUM_REQ{tx_ready}};
      end
      SENSE: begin
        tx_valid = 1'b1;
        tx_data  = 8'hFE;
      end
      default: ;
    endcase
    hs = tx_valid & tx_ready;
  end

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign stall_abort = abort_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    abort_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (any_req) begin
          state_d = XFER;
          grant_d = NUM_REQ'(1) << sel;
          gidx_d  = sel;
        end else if (sense_go) begin
          state_d = SENSE;
        end
      end
      XFER: begin
        if (hs) begin
          stall_cnt_d = '0;
          if (g_last) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end
        end else if (!g_valid) begin
          stall_cnt_d = stall_inc;
          // Owner went quiet mid-message for too long: revoke.
          if (stall_inc == SW'(STALL_MAX)) begin
            abort_d  = 1'b1;
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end
        end
      end
      SENSE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
    if (!midi_rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      abort_q     <= abort_d;
    end
  end

`ifdef MIDI_ACTIVE_SENSE_EN
  logic activity_q, activity_d;
  logic sense_pending_q, sense_pending_d;

  // A handshake coincident with keep_alive still counts as activity.
  always_comb begin
    activity_d      = activity_q | hs;
    sense_pending_d = sense_pending_q;
    if (state_q == SENSE && tx_ready) sense_pending_d = 1'b0;
    if (keep_alive) begin
      if (!(activity_q | hs)) sense_pending_d = 1'b1;
      activity_d = 1'b0;
    end
  end

  always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
    if (!midi_rst_n) begin
      activity_q      <= 1'b0;
      sense_pending_q <= 1'b0;
    end else begin
      activity_q      <= activity_d;
      sense_pending_q <= sense_pending_d;
    end
  end

  assign sense_go = sense_pending_q;
`else
  logic unused_keep_alive;
  assign unused_keep_alive = keep_alive;
  assign sense_go          = 1'b0;
`endif

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Directed bench for midi_tx_arbiter: vector table plus stall, reset
// and Active Sensing sequences (sense counts depend on MIDI_ACTIVE_SENSE_EN).
module tb_midi_tx_arbiter;

  localparam int NR = 4;
  localparam int SM = 16;
`ifdef MIDI_ACTIVE_SENSE_EN
  localparam int EXP_FE = 1;
`else
  localparam int EXP_FE = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          keep_alive;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [NR-1:0] grant;
  logic          busy;
  logic          stall_abort;

  int n_chk;
  int n_fail;
  int fe_cnt;
  int fe_base;

  midi_tx_arbiter #(.NUM_REQ(NR), .STALL_MAX(SM)) dut (
    .midi_system_clock(clk),
    .midi_rst_n(rst_n),
    .keep_alive(keep_alive),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy),
    .stall_abort(stall_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        rdy;
    logic        etv;
    logic [7:0]  etd;
    logic [3:0]  eg;
    logic [3:0]  err;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive after the rising edge, sample on the following falling edge.
  task automatic drive(input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic rdy,
                       input logic ka);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_data   = d;
    req_last   = l;
    tx_ready   = rdy;
    keep_alive = ka;
    @(negedge clk);
    if (tx_valid && tx_ready && tx_data == 8'hFE) fe_cnt++;
  endtask

  task automatic idle_window(input int n);
    for (int i = 0; i < n; i++) drive(4'b0, 32'h0, 4'b0, 1'b1, 1'b0);
  endtask

  task automatic add(input logic [3:0] v, input logic [31:0] d,
                     input logic [3:0] l, input logic rdy,
                     input logic etv, input logic [7:0] etd,
                     input logic [3:0] eg, input logic [3:0] err,
                     input logic eb);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.rdy = rdy;
    r.etv = etv; r.etd = etd; r.eg = eg; r.err = err; r.eb = eb;
    tbl.push_back(r);
  endtask

  task automatic add_idle(input logic [3:0] v, input logic [31:0] d,
                          input logic [3:0] l);
    add(v, d, l, 1'b1, 1'b0, 8'h00, 4'b0, 4'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    fe_cnt = 0;
    rst_n = 1'b0;
    keep_alive = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_ready = 1'b1;

    // single requester, with one backpressure cycle
    add_idle(4'b0001, 32'h0000_0090, 4'b0000);
    add(4'b0001, 32'h0000_0090, 4'b0000, 1'b0, 1, 8'h90, 4'b0001, 4'b0000, 1);
    add(4'b0001, 32'h0000_0090, 4'b0000, 1'b1, 1, 8'h90, 4'b0001, 4'b0001, 1);
    add(4'b0001, 32'h0000_003C, 4'b0000, 1'b1, 1, 8'h3C, 4'b0001, 4'b0001, 1);
    add(4'b0001, 32'h0000_0064, 4'b0001, 1'b1, 1, 8'h64, 4'b0001, 4'b0001, 1);
    add_idle(4'b0000, 32'h0, 4'b0000);
    // round robin: 1, 3, then 1 again
    add_idle(4'b1010, 32'hFA00_F800, 4'b1010);
    add(4'b1010, 32'hFA00_F800, 4'b1010, 1'b1, 1, 8'hF8, 4'b0010, 4'b0010, 1);
    add_idle(4'b1010, 32'hFA00_F800, 4'b1010);
    add(4'b1010, 32'hFA00_F800, 4'b1010, 1'b1, 1, 8'hFA, 4'b1000, 4'b1000, 1);
    add_idle(4'b0010, 32'h0000_F800, 4'b0010);
    add(4'b0010, 32'h0000_F800, 4'b0010, 1'b1, 1, 8'hF8, 4'b0010, 4'b0010, 1);
    add_idle(4'b0000, 32'h0, 4'b0000);
    // atomicity: req 2 message while req 0 waits
    add_idle(4'b0100, 32'h00C0_0000, 4'b0000);
    add(4'b0101, 32'h00C0_0080, 4'b0001, 1'b1, 1, 8'hC0, 4'b0100, 4'b0100, 1);
    add(4'b0101, 32'h0005_0080, 4'b0001, 1'b0, 1, 8'h05, 4'b0100, 4'b0000, 1);
    add(4'b0101, 32'h0005_0080, 4'b0001, 1'b1, 1, 8'h05, 4'b0100, 4'b0100, 1);
    add(4'b0101, 32'h0007_0080, 4'b0101, 1'b1, 1, 8'h07, 4'b0100, 4'b0100, 1);
    add_idle(4'b0001, 32'h0000_0080, 4'b0001);
    add(4'b0001, 32'h0000_0080, 4'b0001, 1'b1, 1, 8'h80, 4'b0001, 4'b0001, 1);
    add_idle(4'b0000, 32'h0, 4'b0000);

    #3;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall_abort", 32'(stall_abort), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].etv));
      chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].etd));
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].err));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_abort", i), 32'(stall_abort), 32'd0);
    end

    // stall: req 1 sends 0xB0 then goes quiet; req 2 waits
    drive(4'b0010, 32'h0000_B000, 4'b0000, 1'b1, 1'b0);
    chk("stall_idle_busy", 32'(busy), 32'd0);
    drive(4'b0010, 32'h0000_B000, 4'b0000, 1'b1, 1'b0);
    chk("stall_first_byte", 32'(tx_data), 32'hB0);
    chk("stall_first_grant", 32'(grant), 32'h2);
    for (int i = 1; i <= SM; i++) begin
      drive(4'b0100, 32'h0099_0000, 4'b0100, 1'b1, 1'b0);
      chk($sformatf("stall_wait%0d_grant", i), 32'(grant), 32'h2);
      chk($sformatf("stall_wait%0d_abort", i), 32'(stall_abort), 32'd0);
      chk($sformatf("stall_wait%0d_txv", i), 32'(tx_valid), 32'd0);
    end
    drive(4'b0100, 32'h0099_0000, 4'b0100, 1'b1, 1'b0);
    chk("stall_abort_pulse", 32'(stall_abort), 32'd1);
    chk("stall_grant_clr", 32'(grant), 32'h0);
    chk("stall_busy_clr", 32'(busy), 32'd0);
    drive(4'b0100, 32'h0099_0000, 4'b0100, 1'b1, 1'b0);
    chk("stall_next_grant", 32'(grant), 32'h4);
    chk("stall_next_data", 32'(tx_data), 32'h99);
    chk("stall_abort_once", 32'(stall_abort), 32'd0);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);

    // reset during byte 2 of 3 from req 3 (rr_ptr is 3 here)
    drive(4'b1000, 32'h1100_0000, 4'b0000, 1'b1, 1'b0);
    drive(4'b1000, 32'h1100_0000, 4'b0000, 1'b1, 1'b0);
    chk("rstx_byte1", 32'(tx_data), 32'h11);
    chk("rstx_grant", 32'(grant), 32'h8);
    drive(4'b1000, 32'h2200_0000, 4'b0000, 1'b1, 1'b0);
    chk("rstx_byte2", 32'(tx_data), 32'h22);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx_tx_valid", 32'(tx_valid), 32'd0);
    chk("rstx_grant_clr", 32'(grant), 32'h0);
    chk("rstx_req_ready", 32'(req_ready), 32'h0);
    chk("rstx_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1001, 32'h5500_0044, 4'b1001, 1'b1, 1'b0);
    drive(4'b1001, 32'h5500_0044, 4'b1001, 1'b1, 1'b0);
    chk("rstx_rr_zero", 32'(grant), 32'h1);
    chk("rstx_rr_data", 32'(tx_data), 32'h44);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);

    // keep_alive right after traffic: no 0xFE
    fe_base = fe_cnt;
    drive(4'b0, 32'h0, 4'b0, 1'b1, 1'b1);
    idle_window(6);
    chk("sense_after_traffic", 32'(fe_cnt - fe_base), 32'd0);
    // idle interval: one 0xFE
    fe_base = fe_cnt;
    drive(4'b0, 32'h0, 4'b0, 1'b1, 1'b1);
    idle_window(6);
    chk("sense_idle", 32'(fe_cnt - fe_base), 32'(EXP_FE));
    // 0xFE itself counts as activity
    fe_base = fe_cnt;
    drive(4'b0, 32'h0, 4'b0, 1'b1, 1'b1);
    idle_window(6);
    chk("sense_after_fe", 32'(fe_cnt - fe_base), 32'd0);
    // pulse coincident with a handshake
    fe_base = fe_cnt;
    drive(4'b0001, 32'h0000_00F8, 4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 32'h0000_00F8, 4'b0001, 1'b1, 1'b1);
    chk("sense_coinc_hs", 32'(tx_valid), 32'd1);
    idle_window(6);
    chk("sense_coinc", 32'(fe_cnt - fe_base), 32'd0);
    // next quiet interval produces 0xFE again
    fe_base = fe_cnt;
    drive(4'b0, 32'h0, 4'b0, 1'b1, 1'b1);
    idle_window(6);
    chk("sense_again", 32'(fe_cnt - fe_base), 32'(EXP_FE));
    chk("sense_end_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
